// File: rtl/digest_scan_out.sv
// Digest serializer: captures the finished Keccak digest on the rising edge of digest_done and streams it LSW-first over valid/ready.
// Optional macro DIGEST_SCAN_OUT_BYTESWAP_EN byte-reverses each presented word for big-endian host display.
module digest_scan_out #(
    parameter int unsigned DIGEST_W = 256,
    parameter int unsigned WORD_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIGEST_W-1:0] digest_in,
    input  logic                digest_done,
    output logic [WORD_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned NWORDS = DIGEST_W / WORD_W;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e              state_q;
    logic                done_q;
    logic                ovr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DIGEST_W-1:0] shreg_q;

    logic capture;
    logic xfer;
    logic is_last;

    function automatic logic [WORD_W-1:0] present(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
`ifdef DIGEST_SCAN_OUT_BYTESWAP_EN
        r = '0;
        for (int unsigned b = 0; b < WORD_W / 8; b++) begin
            r[WORD_W-8-8*b +: 8] = w[8*b +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    assign capture = digest_done & ~done_q;
    assign is_last = (cnt_q == LAST_CNT);
    assign xfer    = (state_q == SEND) & dout_ready;

    // Outputs are pure decodes of registered state, so no input-to-output paths exist.
    assign dout_valid = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign dout_last  = (state_q == SEND) & is_last;
    assign dout       = (state_q == SEND) ? present(shreg_q[WORD_W-1:0]) : '0;
    assign overrun    = ovr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            done_q <= digest_done;
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        shreg_q <= digest_in;
                        cnt_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (xfer && is_last) begin
                        // A capture landing on the final transfer starts the next stream back-to-back.
                        cnt_q <= '0;
                        if (capture) begin
                            shreg_q <= digest_in;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            shreg_q <= shreg_q >> WORD_W;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                        if (capture) begin
                            ovr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digest_scan_out.sv
// Bench for digest_scan_out: queue-based reference model checked every cycle, plus directed literal checks.
module tb_digest_scan_out;

    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NWORDS   = DIGEST_W / WORD_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [DIGEST_W-1:0] digest_in;
    logic                digest_done;
    logic [WORD_W-1:0]   dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                dout_last;
    logic                busy;
    logic                overrun;

    int checks = 0;
    int errors = 0;

    digest_scan_out #(.DIGEST_W(DIGEST_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .reset(reset), .digest_in(digest_in), .digest_done(digest_done),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] host_view(input logic [WORD_W-1:0] w);
`ifdef DIGEST_SCAN_OUT_BYTESWAP_EN
        return {<<8{w}};
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: pending words of the current digest, a sticky overrun flag, previous done.
    logic [WORD_W-1:0] m_words[$];
    bit                m_prev = 1'b1;
    bit                m_ovr  = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_words.delete();
                m_prev = 1'b1;
                m_ovr  = 1'b0;
            end else begin
                bit cap;
                cap = digest_done && !m_prev;
                if (m_words.size() > 0 && dout_ready) void'(m_words.pop_front());
                if (cap) begin
                    if (m_words.size() == 0) begin
                        for (int k = 0; k < NWORDS; k++) m_words.push_back(digest_in[k*WORD_W +: WORD_W]);
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
                m_prev = digest_done;
            end
            #1;
            check("dout", dout, (m_words.size() > 0) ? host_view(m_words[0]) : '0);
            check("valid", 32'(dout_valid), 32'(m_words.size() > 0));
            check("last", 32'(dout_last), 32'(m_words.size() == 1));
            check("busy", 32'(busy), 32'(m_words.size() > 0));
            check("overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    logic [DIGEST_W-1:0] d1, d2, d3;

    initial begin
        for (int k = 0; k < NWORDS; k++) begin
            d1[k*WORD_W +: WORD_W] = 32'h11111111 * (k + 1);
            d2[k*WORD_W +: WORD_W] = 32'hDEAD0000 + 32'(k);
            d3[k*WORD_W +: WORD_W] = (k == 0) ? 32'h03020100 : 32'hA0000000 + 32'(k);
        end
        reset = 1'b1; digest_done = 1'b1; dout_ready = 1'b1; digest_in = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_dout", dout, 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // Basic stream
        digest_done = 1'b0; tick();
        digest_in = d1; digest_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("basic_word", dout, 32'h11111111 * (i + 1));
            check("basic_last", 32'(dout_last), 32'(i == 7));
        end
        tick();
        check("basic_idle", 32'(busy), 32'h0);

        // Backpressure on word 1
        digest_done = 1'b0; tick();
        digest_done = 1'b1;
        tick(); check("bp_w0", dout, 32'h11111111);
        tick(); check("bp_w1", dout, 32'h22222222);
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", dout, 32'h22222222);
            check("bp_valid", 32'(dout_valid), 32'h1);
        end
        dout_ready = 1'b1;
        tick(); check("bp_w2", dout, 32'h33333333);
        for (int i = 0; i < 6; i++) tick();
        check("bp_idle", 32'(dout_valid), 32'h0);

        // Overrun mid-stream, then capture coinciding with the last transfer
        digest_done = 1'b0; tick();
        digest_done = 1'b1;
        tick(); tick(); tick(); tick();
        check("ovr_w3", dout, 32'h44444444);
        digest_done = 1'b0;
        tick();
        digest_in = d2; digest_done = 1'b1;
        tick();
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_w5", dout, 32'h66666666);
        digest_done = 1'b0;
        tick(); tick();
        check("ovr_w7", dout, 32'h88888888);
        digest_in = d3; digest_done = 1'b1;
        tick();
`ifdef DIGEST_SCAN_OUT_BYTESWAP_EN
        check("swap_w0", dout, 32'h00010203);
`else
        check("swap_w0", dout, 32'h03020100);
`endif
        check("b2b_valid", 32'(dout_valid), 32'h1);
        check("b2b_overrun", 32'(overrun), 32'h1);
        digest_in = d2;
        for (int i = 0; i < 8; i++) tick();
        check("b2b_idle", 32'(dout_valid), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);

        // Reset mid-stream with digest_done held high
        digest_done = 1'b0; tick();
        digest_in = d1; digest_done = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("rs_w5", dout, 32'h66666666);
        reset = 1'b1;
        tick();
        check("rs_dout", dout, 32'h0);
        check("rs_valid", 32'(dout_valid), 32'h0);
        check("rs_last", 32'(dout_last), 32'h0);
        check("rs_busy", 32'(busy), 32'h0);
        check("rs_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        tick(); tick();
        check("rs_nocap", 32'(dout_valid), 32'h0);
        digest_done = 1'b0; tick();
        digest_done = 1'b1;
        tick();
        check("rs_recap", dout, 32'h11111111);
        for (int i = 0; i < 10; i++) tick();
        check("end_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digest_scan_out.md
# digest_scan_out

Output serializer for the SHA3-256 / Keccak core. It sits between the round pipeline's completed-state register and the host side, on the opposite end from the block-loading input buffer. When the core signals that rounds have completed, the block captures the 256-bit digest. It then streams the digest out as fixed-width words over a valid/ready handshake, least-significant word first.

## Interface
Parameters:
- DIGEST_W, 256, digest width in bits; must be a multiple of WORD_W.
- WORD_W, 32, output word width in bits; must be a multiple of 8.
- Derived: NWORDS = DIGEST_W/WORD_W (8 by default); CNT_W = clog2(NWORDS), minimum 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- digest_in  in  DIGEST_W  digest from the core state register, bits [DIGEST_W-1:0].
- digest_done  in  1  core rounds-completed level flag. Capture triggers on its rising edge.
- dout  out  WORD_W  current output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts the word at this posedge.
- dout_last  out  1  current word is word NWORDS-1.
- busy  out  1  a digest is captured and not yet fully sent.
- overrun  out  1  sticky: a digest_done rising edge was dropped while busy.

## Operation
- Registers:
  - done_q: previous digest_done. Reset value is 1, because the core's flag also resets high; this prevents a spurious capture right after reset.
  - shreg: DIGEST_W-bit capture/shift register.
  - cnt: CNT_W-bit word counter.
  - state: IDLE or SEND.
  - ovr: sticky overrun flag.
- The capture event is digest_done & ~done_q, evaluated every cycle. done_q <= digest_done every cycle.
- IDLE:
  - dout_valid=0, dout_last=0, busy=0, dout=0.
  - On a capture event: shreg <= digest_in, cnt <= 0, state -> SEND.
- SEND:
  - dout_valid=1, busy=1.
  - dout = shreg[WORD_W-1:0], with the optional byte swap applied.
  - dout_last = (cnt == NWORDS-1).
- Word transfer: dout_valid & dout_ready at posedge.
  - If not last: shreg >>= WORD_W (zero fill), cnt <= cnt+1.
  - If last: state -> IDLE, cnt <= 0.
- Backpressure: while dout_valid & ~dout_ready, dout, dout_last and cnt must not change.
- Capture event in SEND, not coinciding with the last transfer: the digest is discarded, ovr <= 1, and the current stream continues unaffected.
- Capture event in the same cycle as the last transfer: the new digest is captured (shreg <= digest_in, cnt <= 0), state stays SEND, and ovr is not set.
- overrun = ovr. It is cleared only by reset.
- Reset (including mid-stream) forces:
  - state=IDLE, cnt=0, shreg=0, ovr=0, done_q=1.
  - All outputs return to 0 at the next edge. A partially sent digest is abandoned.

## Timing
- Reset values: dout=0, dout_valid=0, dout_last=0, busy=0, overrun=0.
- Capture latency: if digest_done is first sampled high at posedge N (with done_q=0), dout_valid and busy are high after posedge N, and word 0 is presented in cycle N+1.
- Throughput: one word per cycle while dout_ready=1. With ready held high, a full digest takes NWORDS cycles (8 cycles by default).
- After the last transfer at posedge M, dout_valid is low in cycle M+1. The exception is a same-cycle capture, in which case word 0 of the new digest is presented in cycle M+1.
- digest_in is sampled only at the capture edge. Later changes to it do not affect the stream.
- All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.

## Configuration
- DIGEST_SCAN_OUT_BYTESWAP_EN:
  - Defined: dout presents each word byte-reversed. Byte 0 (shreg[7:0]) appears on dout[WORD_W-1:WORD_W-8]. This gives big-endian hex order for host display.
  - Undefined: dout = shreg[WORD_W-1:0] unchanged.
- Word order and handshake are identical in both builds.

## Test plan
- Basic stream:
  - Stimulus: reset; digest_in = {32'h88888888, 32'h77777777, …, 32'h11111111}; digest_done 0→1; dout_ready=1.
  - Required response: words 11111111, 22222222, … 88888888 on 8 consecutive cycles starting one cycle after the edge; dout_last only with 88888888; busy then drops.
- Backpressure:
  - Stimulus: same digest; drop dout_ready for 3 cycles while word 22222222 is presented.
  - Required response: dout holds 22222222 and dout_valid stays 1 for those cycles; no word is lost or duplicated.
- Overrun:
  - Stimulus: pulse digest_done low→high during word 3 with a different digest_in.
  - Required response: overrun=1 and stays 1; the original 8 words complete unchanged. A second capture edge issued at the last transfer is accepted and streams with overrun still 1.
- Reset behaviour:
  - Stimulus: assert reset during word 5. Then deassert reset with digest_done held high.
  - Required response: all outputs 0 the next cycle. No capture occurs until digest_done falls and rises again.
- Byte swap, DIGEST_SCAN_OUT_BYTESWAP_EN defined:
  - Stimulus: digest_in[31:0] = 32'h03020100.
  - Required response: first dout = 32'h00010203; with the macro undefined, first dout = 32'h03020100.
